// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped interrupt timer.
// Register offsets, FSM encodings, mode codes and CTRL bit positions.
package timer_pkg;

   localparam logic [1:0] TMR_CTRL   = 2'd0;
   localparam logic [1:0] TMR_PRESET = 2'd1;
   localparam logic [1:0] TMR_COUNT  = 2'd2;

   localparam logic [1:0] TS_IDLE = 2'd0;
   localparam logic [1:0] TS_LOAD = 2'd1;
   localparam logic [1:0] TS_CNT  = 2'd2;
   localparam logic [1:0] TS_INT  = 2'd3;

   localparam logic [1:0] TM_ONESHOT = 2'b00;
   localparam logic [1:0] TM_RELOAD  = 2'b01;

   localparam int CB_EN      = 0;
   localparam int CB_MODE_LO = 1;
   localparam int CB_MODE_HI = 2;
   localparam int CB_IM      = 3;

   function automatic logic is_reload(input logic [3:0] c);
      return c[CB_MODE_HI:CB_MODE_LO] == TM_RELOAD;
   endfunction

endpackage

// File: rtl/timer_irq_tick_div.sv
// Prescaler: one-cycle tick every PRESCALE clocks, restarted by clr.
// With PRESCALE = 1 the tick is high whenever clr is low.
module tick_div #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] cnt;

   assign tick = !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/timer_irq.sv
// Programmable down-counter with one-shot / auto-reload interrupt.
// Bus side: CTRL, PRESET (rw) and COUNT (ro) word registers.
module timer_irq
   import timer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic [1:0]  state;
   logic        irqf;
   logic        tick;
   logic        en;
   logic        reload;
   logic        wr_ctrl;
   logic        wr_pre;
   logic        expire;

   assign en      = ctrl[CB_EN];
   assign reload  = is_reload(ctrl);
   assign wr_ctrl = we && (addr == TMR_CTRL);
   assign wr_pre  = we && (addr == TMR_PRESET);
   assign expire  = (state == TS_CNT) && en && tick && (count <= 32'd1);
   assign irq     = irqf & ctrl[CB_IM];

   tick_div #(.PRESCALE(PRESCALE)) u_div (
      .clk   (clk),
      .reset (reset),
      .clr   (state != TS_CNT),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= TS_IDLE;
         count <= '0;
      end else begin
         unique case (state)
            TS_IDLE: if (en) state <= TS_LOAD;
            TS_LOAD: begin
               count <= preset;
               state <= TS_CNT;
            end
            TS_CNT: begin
               if (!en) begin
                  state <= TS_IDLE;
               end else if (tick) begin
                  if (count > 32'd1) begin
                     count <= count - 32'd1;
                  end else begin
                     count <= '0;
                     state <= TS_INT;
                  end
               end
            end
            TS_INT: state <= TS_IDLE;
         endcase
      end
   end

   // A bus write to CTRL overrides the one-shot self-disable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl <= '0;
      end else if (wr_ctrl) begin
         ctrl <= wdata[3:0];
      end else if (state == TS_INT && !reload) begin
         ctrl[CB_EN] <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         preset <= '0;
      end else if (wr_pre) begin
         preset <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irqf <= 1'b0;
      end else if (expire) begin
         irqf <= 1'b1;
      end else if (wr_ctrl || wr_pre) begin
         irqf <= 1'b0;
      end else if (state == TS_INT && reload) begin
         irqf <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         TMR_CTRL:   rdata = {28'd0, ctrl};
         TMR_PRESET: rdata = preset;
         TMR_COUNT:  rdata = count;
         default:    rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq with hand-computed expectations.
// A second instance with PRESCALE = 4 shares the bus.
module tb_timer_irq;
   import timer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;
   logic [31:0] rdata4;
   logic        irq4;
   logic [31:0] v;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   timer_irq #(.PRESCALE(1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   timer_irq #(.PRESCALE(4)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata4),
      .irq   (irq4)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      rd(TMR_CTRL, v);   chk("rst_ctrl", v, 32'd0);
      rd(TMR_PRESET, v); chk("rst_preset", v, 32'd0);
      rd(TMR_COUNT, v);  chk("rst_count", v, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);

      // async reset while counting
      wr(TMR_PRESET, 32'd5);
      wr(TMR_CTRL, 32'h9);
      step(4);
      rd(TMR_COUNT, v); chk("pre_rst_count", v, 32'd3);
      #2 reset = 1'b0;
      #1;
      chk("arst_irq", 32'(irq), 32'd0);
      rd(TMR_COUNT, v); chk("arst_count", v, 32'd0);
      rd(TMR_CTRL, v);  chk("arst_ctrl", v, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rd(TMR_CTRL, v);   chk("rel_ctrl", v, 32'd0);
      rd(TMR_PRESET, v); chk("rel_preset", v, 32'd0);
      rd(TMR_COUNT, v);  chk("rel_count", v, 32'd0);
      step(10);
      chk("rel_noirq", 32'(irq), 32'd0);

      // one-shot, PRESET = 5
      wr(TMR_PRESET, 32'd5);
      wr(TMR_CTRL, 32'h9);
      for (int k = 1; k <= 7; k++) begin
         step(1);
         if (k >= 2) begin
            rd(TMR_COUNT, v);
            chk("os_count", v, 32'(7 - k));
         end
         chk("os_irq", 32'(irq), 32'(k == 7));
      end
      step(1);
      rd(TMR_CTRL, v); chk("os_ctrl", v, 32'h8);
      chk("os_hold", 32'(irq), 32'd1);
      step(3);
      chk("os_hold2", 32'(irq), 32'd1);
      wr(TMR_CTRL, 32'h8);
      chk("os_clear", 32'(irq), 32'd0);

      // auto-reload, PRESET = 3: pulses at E+5, +6 each
      wr(TMR_PRESET, 32'd3);
      wr(TMR_CTRL, 32'hB);
      for (int k = 1; k <= 24; k++) begin
         step(1);
         chk("ar_irq", 32'(irq), 32'(k >= 5 && ((k - 5) % 6) == 0));
      end
      wr(TMR_CTRL, 32'h0);
      step(4);

      // masked expiry, then CTRL write clears the flag
      wr(TMR_PRESET, 32'd2);
      wr(TMR_CTRL, 32'h1);
      step(8);
      chk("mask_irq", 32'(irq), 32'd0);
      rd(TMR_COUNT, v); chk("mask_count", v, 32'd0);
      rd(TMR_CTRL, v);  chk("mask_ctrl", v, 32'd0);
      wr(TMR_CTRL, 32'h8);
      chk("mask_unmask", 32'(irq), 32'd0);
      step(2);
      chk("mask_unmask2", 32'(irq), 32'd0);

      // disable mid-count at COUNT = 10
      wr(TMR_PRESET, 32'd20);
      wr(TMR_CTRL, 32'h1);
      step(12);
      rd(TMR_COUNT, v); chk("dis_at10", v, 32'd10);
      wr(TMR_CTRL, 32'h0);
      step(3);
      rd(TMR_COUNT, v); chk("dis_frozen", v, 32'd9);
      step(2);
      rd(TMR_COUNT, v); chk("dis_frozen2", v, 32'd9);
      wr(TMR_CTRL, 32'h1);
      step(2);
      rd(TMR_COUNT, v); chk("dis_reload", v, 32'd20);
      wr(TMR_CTRL, 32'h0);
      step(3);

      // PRESET = 0 and 1 expire after one tick
      for (int p = 0; p <= 1; p++) begin
         wr(TMR_PRESET, 32'(p));
         wr(TMR_CTRL, 32'h9);
         step(2);
         chk("p01_early", 32'(irq), 32'd0);
         step(1);
         chk("p01_int", 32'(irq), 32'd1);
         wr(TMR_CTRL, 32'h8);
      end

      // max PRESET
      wr(TMR_PRESET, 32'hFFFF_FFFF);
      wr(TMR_CTRL, 32'h1);
      step(2);
      rd(TMR_COUNT, v); chk("max_load", v, 32'hFFFF_FFFF);
      step(1);
      rd(TMR_COUNT, v); chk("max_dec", v, 32'hFFFF_FFFE);
      wr(TMR_CTRL, 32'h0);
      step(3);

      // CTRL write on the one-shot EN-clear edge wins
      wr(TMR_PRESET, 32'd2);
      wr(TMR_CTRL, 32'h9);
      step(4);
      chk("sim_int", 32'(irq), 32'd1);
      wr(TMR_CTRL, 32'h9);
      rd(TMR_CTRL, v); chk("sim_ctrl", v, 32'h9);
      chk("sim_irqclr", 32'(irq), 32'd0);
      step(2);
      rd(TMR_COUNT, v); chk("sim_restart", v, 32'd2);
      step(2);
      chk("sim_int2", 32'(irq), 32'd1);
      wr(TMR_CTRL, 32'h8);
      step(3);

      // PRESET write during CNT takes effect on next LOAD
      wr(TMR_PRESET, 32'd6);
      wr(TMR_CTRL, 32'h9);
      step(3);
      wr(TMR_PRESET, 32'd3);
      rd(TMR_COUNT, v); chk("pw_count", v, 32'd4);
      step(4);
      chk("pw_int", 32'(irq), 32'd1);
      rd(TMR_COUNT, v);  chk("pw_zero", v, 32'd0);
      rd(TMR_PRESET, v); chk("pw_preset", v, 32'd3);
      step(2);
      wr(TMR_CTRL, 32'h9);
      step(2);
      rd(TMR_COUNT, v); chk("pw_newload", v, 32'd3);
      step(2);
      chk("pw_early", 32'(irq), 32'd0);
      step(1);
      chk("pw_int2", 32'(irq), 32'd1);
      wr(TMR_CTRL, 32'h0);
      step(20);

      // PRESCALE = 4, PRESET = 2: INT 10 edges after EN write
      wr(TMR_PRESET, 32'd2);
      wr(TMR_CTRL, 32'h9);
      step(9);
      chk("ps_early", 32'(irq4), 32'd0);
      step(1);
      chk("ps_int", 32'(irq4), 32'd1);
      chk("ps_fast", 32'(irq), 32'd1);
      wr(TMR_CTRL, 32'h8);
      chk("ps_clear", 32'(irq4), 32'd0);
      addr = TMR_COUNT;
      #1;
      chk("ps_count", rdata4, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
